// File: rtl/spi_master_burst.sv
// Parametrised full-duplex SPI master with CS-held bursts and per-frame D/C.
// Ports: clk/rst; tx_valid/tx_ready/tx_data/tx_dc/tx_last frame input;
//        rx_valid/rx_data captured frame; busy; sck/mosi/miso/cs_n/dc pins.
module spi_master_burst #(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 50,
    parameter int CPOL      = 0,
    parameter int CPHA      = 0,
    parameter int LSB_FIRST = 0,
    parameter int CS_GAP    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_dc,
    input  logic              tx_last,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              sck,
    output logic              mosi,
    input  logic              miso,
    output logic              cs_n,
    output logic              dc
);

    localparam int   DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int   CNT_W      = $clog2(2 * DATA_W + CS_GAP + 1);
    localparam logic L_SCK_IDLE = (CPOL != 0);
    localparam logic L_CPHA     = (CPHA != 0);
    localparam logic L_LSB      = (LSB_FIRST != 0);

    typedef enum logic [2:0] {
        S_IDLE, S_LEAD, S_XFER, S_WAIT, S_TRAIL, S_GAP
    } state_t;

    state_t            r_state;
    logic [DIV_W-1:0]  r_div;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_tx_sh;
    logic [DATA_W-1:0] r_rx_sh;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_rx_valid;
    logic              r_tx_ready;
    logic              r_busy;
    logic              r_sck;
    logic              r_mosi;
    logic              r_cs_n;
    logic              r_dc;
    logic              r_last;

    logic              w_tick;
    logic              w_accept;
    logic              w_final;
    logic              w_sample;
    logic              w_shift;
    logic [DATA_W-1:0] w_rx_next;
    logic [DATA_W-1:0] w_load_sh;
    logic              w_load_mosi;

    function automatic logic first_bit(input logic [DATA_W-1:0] v);
        return L_LSB ? v[0] : v[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v);
        return L_LSB ? (v >> 1) : (v << 1);
    endfunction

    assign w_tick   = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_accept = tx_valid & r_tx_ready;
    assign w_final  = (r_cnt == CNT_W'(2 * DATA_W - 1));
    // Even tick count = leading SCK edge; CPHA picks which edge samples.
    assign w_sample = (r_cnt[0] == L_CPHA);
    // The final trailing edge never shifts, so mosi keeps the last bit.
    assign w_shift  = (r_cnt[0] != L_CPHA) & ~w_final;

    assign w_rx_next = L_LSB ? {miso, r_rx_sh[DATA_W-1:1]}
                             : {r_rx_sh[DATA_W-2:0], miso};

    // CPHA=0 presents the first bit before the first edge; CPHA=1 on it.
    assign w_load_sh   = L_CPHA ? tx_data : shift_out(tx_data);
    assign w_load_mosi = L_CPHA ? r_mosi : first_bit(tx_data);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_div      <= '0;
            r_cnt      <= '0;
            r_tx_sh    <= '0;
            r_rx_sh    <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_tx_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_sck      <= L_SCK_IDLE;
            r_mosi     <= 1'b0;
            r_cs_n     <= 1'b1;
            r_dc       <= 1'b0;
            r_last     <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (r_state == S_IDLE || r_state == S_WAIT || w_tick)
                r_div <= '0;
            else
                r_div <= r_div + 1'b1;

            unique case (r_state)
                S_IDLE: begin
                    r_tx_ready <= ~w_accept;
                    if (w_accept) begin
                        r_tx_sh <= w_load_sh;
                        r_mosi  <= w_load_mosi;
                        r_dc    <= tx_dc;
                        r_last  <= tx_last;
                        r_cnt   <= '0;
                        r_cs_n  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_LEAD;
                    end
                end
                S_LEAD: begin
                    if (w_tick)
                        r_state <= S_XFER;
                end
                S_XFER: begin
                    if (w_tick) begin
                        r_sck <= ~r_sck;
                        r_cnt <= r_cnt + 1'b1;
                        if (w_sample)
                            r_rx_sh <= w_rx_next;
                        if (w_shift) begin
                            r_mosi  <= first_bit(r_tx_sh);
                            r_tx_sh <= shift_out(r_tx_sh);
                        end
                        if (w_final) begin
                            // CPHA=1 takes its last sample on this edge.
                            r_rx_data  <= L_CPHA ? w_rx_next : r_rx_sh;
                            r_rx_valid <= 1'b1;
                            r_cnt      <= '0;
                            if (r_last) begin
                                r_state <= S_TRAIL;
                            end else begin
                                r_state    <= S_WAIT;
                                r_tx_ready <= 1'b1;
                            end
                        end
                    end
                end
                S_WAIT: begin
                    if (w_accept) begin
                        r_tx_sh    <= w_load_sh;
                        r_mosi     <= w_load_mosi;
                        r_dc       <= tx_dc;
                        r_last     <= tx_last;
                        r_cnt      <= '0;
                        r_tx_ready <= 1'b0;
                        r_state    <= S_XFER;
                    end
                end
                S_TRAIL: begin
                    if (w_tick) begin
                        r_cs_n  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (w_tick) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CNT_W'(CS_GAP - 1)) begin
                            r_cnt      <= '0;
                            r_busy     <= 1'b0;
                            r_tx_ready <= 1'b1;
                            r_state    <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign tx_ready = r_tx_ready;
    assign rx_valid = r_rx_valid;
    assign rx_data  = r_rx_data;
    assign busy     = r_busy;
    assign sck      = r_sck;
    assign mosi     = r_mosi;
    assign cs_n     = r_cs_n;
    assign dc       = r_dc;

endmodule
